// File: rtl/proc_mem_pkg.sv
// Shared types and constants for the processor/memory arbiter.
//   arb_state_t : arbiter FSM state (IDLE, BUSY)
//   owner_t     : which processor port owns / last won the memory
//   MEMREQ_*    : memory request type encoding
package proc_mem_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_IMEM = 1'b0,
        OWN_DMEM = 1'b1
    } owner_t;

    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;

    localparam int unsigned STARVE_W = 4;
    localparam logic [STARVE_W-1:0] STARVE_SAT = 4'hF;

endpackage

// File: rtl/arb_grant2.sv
// Combinational two-requester grant (imem vs dmem).
//   i_imem_val, i_dmem_val : requester valid bits
//   i_last_dmem            : 1 when the previous grant went to dmem
//   i_starve_cnt           : consecutive imem losses
//   o_grant_dmem_c         : 1 = dmem wins, 0 = imem wins (or nobody valid)
//   o_any_val_c            : at least one requester is valid
module arb_grant2
    import proc_mem_pkg::*;
#(
    parameter int unsigned RR_MODE    = 0,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic                i_imem_val,
    input  logic                i_dmem_val,
    input  logic                i_last_dmem,
    input  logic [STARVE_W-1:0] i_starve_cnt,
    output logic                o_grant_dmem_c,
    output logic                o_any_val_c
);

    localparam logic [STARVE_W-1:0] STARVE_LIMIT = STARVE_W'(MAX_STARVE);

    // Single requester wins outright; contention resolved by policy.
    always_comb begin
        o_grant_dmem_c = 1'b0;
        o_any_val_c    = i_imem_val | i_dmem_val;
        if (i_dmem_val && !i_imem_val) begin
            o_grant_dmem_c = 1'b1;
        end else if (i_dmem_val && i_imem_val) begin
            if (RR_MODE != 0) begin
                o_grant_dmem_c = !i_last_dmem;
            end else begin
                o_grant_dmem_c = (i_starve_cnt != STARVE_LIMIT);
            end
        end
    end

endmodule

// File: rtl/proc_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch (imem) and
// data (dmem) ports. One transaction outstanding; response routed to owner.
//   clk, rst (async, active-low)
//   imemreq_* / imemresp_* : fetch port
//   dmemreq_* / dmemresp_* : data port
//   memreq_* / memresp_*   : memory side
//   err                    : sticky, response seen with nothing outstanding
module proc_mem_arbiter
    import proc_mem_pkg::*;
#(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned RR_MODE    = 0,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          imemreq_val,
    output logic          imemreq_rdy,
    input  logic [AW-1:0] imemreq_addr,
    output logic          imemresp_val,
    output logic [DW-1:0] imemresp_data,
    input  logic          dmemreq_val,
    output logic          dmemreq_rdy,
    input  logic          dmemreq_type,
    input  logic [AW-1:0] dmemreq_addr,
    input  logic [DW-1:0] dmemreq_wdata,
    output logic          dmemresp_val,
    output logic [DW-1:0] dmemresp_rdata,
    output logic          memreq_val,
    input  logic          memreq_rdy,
    output logic          memreq_type,
    output logic [AW-1:0] memreq_addr,
    output logic [DW-1:0] memreq_wdata,
    input  logic          memresp_val,
    input  logic [DW-1:0] memresp_data,
    output logic          err
);

    arb_state_t          r_state;
    owner_t              r_owner;
    owner_t              r_last_grant;
    logic [STARVE_W-1:0] r_starve_cnt;
    logic                r_err;

    logic w_grant_dmem;
    logic w_any_val;
    logic w_idle;
    logic w_busy;
    logic w_accept;

    arb_grant2 #(
        .RR_MODE    (RR_MODE),
        .MAX_STARVE (MAX_STARVE)
    ) u_grant (
        .i_imem_val     (imemreq_val),
        .i_dmem_val     (dmemreq_val),
        .i_last_dmem    (r_last_grant == OWN_DMEM),
        .i_starve_cnt   (r_starve_cnt),
        .o_grant_dmem_c (w_grant_dmem),
        .o_any_val_c    (w_any_val)
    );

    // Handshake outputs are forced low while reset is asserted.
    assign w_idle = rst && (r_state == IDLE);
    assign w_busy = rst && (r_state == BUSY);

    // Request forwarding from the current winner.
    assign memreq_val   = w_idle && w_any_val;
    assign memreq_type  = w_grant_dmem ? dmemreq_type  : MEMREQ_READ;
    assign memreq_addr  = w_grant_dmem ? dmemreq_addr  : imemreq_addr;
    assign memreq_wdata = w_grant_dmem ? dmemreq_wdata : '0;
    assign w_accept     = memreq_val && memreq_rdy;

    assign imemreq_rdy = w_accept && !w_grant_dmem;
    assign dmemreq_rdy = w_accept &&  w_grant_dmem;

    // Response routing to the owner of the outstanding transaction.
    assign imemresp_val   = w_busy && memresp_val && (r_owner == OWN_IMEM);
    assign dmemresp_val   = w_busy && memresp_val && (r_owner == OWN_DMEM);
    assign imemresp_data  = memresp_data;
    assign dmemresp_rdata = memresp_data;
    assign err            = r_err;

    // Arbiter FSM and bookkeeping registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_owner      <= OWN_IMEM;
            r_last_grant <= OWN_IMEM;
            r_starve_cnt <= '0;
            r_err        <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Nothing outstanding: any response is spurious.
                    if (memresp_val) begin
                        r_err <= 1'b1;
                    end
                    if (w_accept) begin
                        r_state      <= BUSY;
                        r_owner      <= w_grant_dmem ? OWN_DMEM : OWN_IMEM;
                        r_last_grant <= w_grant_dmem ? OWN_DMEM : OWN_IMEM;
                        if (!w_grant_dmem) begin
                            r_starve_cnt <= '0;
                        end else if (imemreq_val && (r_starve_cnt != STARVE_SAT)) begin
                            r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
                        end
                    end
                end
                BUSY: begin
                    if (memresp_val) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_proc_mem_arbiter.sv
// Self-checking bench: dut0 uses dmem priority with starvation guard,
// dut1 uses round-robin; both share the same stimulus.
module tb_proc_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        ival;
    logic [31:0] iaddr;
    logic        dval;
    logic        dtype;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        mrdy;
    logic        mrv;
    logic [31:0] mrd;

    logic        irdy0, iresp0, drdy0, dresp0, mval0, mtype0, err0;
    logic [31:0] idata0, ddata0, maddr0, mwdata0;
    logic        irdy1, iresp1, drdy1, dresp1, mval1, mtype1, err1;
    logic [31:0] idata1, ddata1, maddr1, mwdata1;

    int n_checks = 0;
    int n_err    = 0;

    proc_mem_arbiter #(.AW(32), .DW(32), .RR_MODE(0), .MAX_STARVE(4)) dut0 (
        .clk(clk), .rst(rst),
        .imemreq_val(ival), .imemreq_rdy(irdy0), .imemreq_addr(iaddr),
        .imemresp_val(iresp0), .imemresp_data(idata0),
        .dmemreq_val(dval), .dmemreq_rdy(drdy0), .dmemreq_type(dtype),
        .dmemreq_addr(daddr), .dmemreq_wdata(dwdata),
        .dmemresp_val(dresp0), .dmemresp_rdata(ddata0),
        .memreq_val(mval0), .memreq_rdy(mrdy), .memreq_type(mtype0),
        .memreq_addr(maddr0), .memreq_wdata(mwdata0),
        .memresp_val(mrv), .memresp_data(mrd), .err(err0)
    );

    proc_mem_arbiter #(.AW(32), .DW(32), .RR_MODE(1), .MAX_STARVE(4)) dut1 (
        .clk(clk), .rst(rst),
        .imemreq_val(ival), .imemreq_rdy(irdy1), .imemreq_addr(iaddr),
        .imemresp_val(iresp1), .imemresp_data(idata1),
        .dmemreq_val(dval), .dmemreq_rdy(drdy1), .dmemreq_type(dtype),
        .dmemreq_addr(daddr), .dmemreq_wdata(dwdata),
        .dmemresp_val(dresp1), .dmemresp_rdata(ddata1),
        .memreq_val(mval1), .memreq_rdy(mrdy), .memreq_type(mtype1),
        .memreq_addr(maddr1), .memreq_wdata(mwdata1),
        .memresp_val(mrv), .memresp_data(mrd), .err(err1)
    );

    // {irdy, drdy, mval, mtype, iresp, dresp, err}
    logic [6:0] ctl0;
    assign ctl0 = {irdy0, drdy0, mval0, mtype0, iresp0, dresp0, err0};

    typedef struct {
        logic        rst;
        logic        ival;
        logic [31:0] iaddr;
        logic        dval;
        logic        dtype;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        mrdy;
        logic        mrv;
        logic [31:0] mrd;
        logic [6:0]  e_ctl;
        logic [31:0] e_maddr;
        logic [31:0] e_mwdata;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] ia,
                                input logic dv, input logic dt, input logic [31:0] da,
                                input logic [31:0] dw, input logic rdy, input logic rv,
                                input logic [31:0] rd, input logic [6:0] ec,
                                input logic [31:0] ema, input logic [31:0] emw);
        vec_t v;
        v.rst = r; v.ival = iv; v.iaddr = ia; v.dval = dv; v.dtype = dt;
        v.daddr = da; v.dwdata = dw; v.mrdy = rdy; v.mrv = rv; v.mrd = rd;
        v.e_ctl = ec; v.e_maddr = ema; v.e_mwdata = emw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        ival = 0; iaddr = 0; dval = 0; dtype = 0; daddr = 0; dwdata = 0;
        mrdy = 0; mrv = 0; mrd = 0;
    endtask

    task automatic apply_reset;
        rst = 1'b0;
        clear_inputs();
        #2;
        chk("reset_ctl", 32'(ctl0), 32'h0);
        chk("reset_err1", 32'(err1), 32'h0);
        tick();
        rst = 1'b1;
    endtask

    logic exp0 [10];
    logic e;

    initial begin
        rst = 1'b0;
        clear_inputs();

        // rst iv ia dv dt da dw rdy rv rd  {irdy,drdy,mval,mtype,iresp,dresp,err} maddr mwdata
        vecs[0]  = mk(0,1,32'h100,0,0,0,0,1,1,0,            7'b0000000, 0, 0);
        vecs[1]  = mk(1,1,32'h100,0,0,0,0,1,0,0,            7'b1010000, 32'h100, 0);
        vecs[2]  = mk(1,0,0,0,0,0,0,1,0,0,                  7'b0000000, 0, 0);
        vecs[3]  = mk(1,0,0,0,0,0,0,0,1,32'hDEADBEEF,       7'b0000100, 0, 0);
        vecs[4]  = mk(1,0,0,0,0,0,0,0,0,0,                  7'b0000000, 0, 0);
        vecs[5]  = mk(1,0,0,1,1,32'h200,32'h12345678,0,0,0, 7'b0011000, 32'h200, 32'h12345678);
        vecs[6]  = mk(1,0,0,1,1,32'h200,32'h12345678,0,0,0, 7'b0011000, 32'h200, 32'h12345678);
        vecs[7]  = mk(1,0,0,1,1,32'h200,32'h12345678,0,0,0, 7'b0011000, 32'h200, 32'h12345678);
        vecs[8]  = mk(1,0,0,1,1,32'h200,32'h12345678,1,0,0, 7'b0111000, 32'h200, 32'h12345678);
        vecs[9]  = mk(1,0,0,0,0,0,0,1,0,0,                  7'b0000000, 0, 0);
        vecs[10] = mk(1,0,0,0,0,0,0,0,1,32'hCAFEF00D,       7'b0000010, 0, 0);
        vecs[11] = mk(1,0,0,0,0,0,0,0,0,0,                  7'b0000000, 0, 0);
        vecs[12] = mk(1,1,32'h300,1,0,32'h400,32'h55,0,0,0, 7'b0010000, 32'h400, 32'h55);
        vecs[13] = mk(1,1,32'h300,0,0,32'h400,32'h55,0,0,0, 7'b0010000, 32'h300, 0);
        vecs[14] = mk(1,0,0,0,0,0,0,0,0,0,                  7'b0000000, 0, 0);
        vecs[15] = mk(1,0,0,0,0,0,0,0,1,32'h11,             7'b0000000, 0, 0);
        vecs[16] = mk(1,0,0,0,0,0,0,0,0,0,                  7'b0000001, 0, 0);

        // Table-driven single-transaction, stall and spurious-response vectors.
        for (int k = 0; k < NVEC; k++) begin
            rst = vecs[k].rst; ival = vecs[k].ival; iaddr = vecs[k].iaddr;
            dval = vecs[k].dval; dtype = vecs[k].dtype; daddr = vecs[k].daddr;
            dwdata = vecs[k].dwdata; mrdy = vecs[k].mrdy; mrv = vecs[k].mrv;
            mrd = vecs[k].mrd;
            #2;
            chk($sformatf("vec%0d_ctl", k), 32'(ctl0), 32'(vecs[k].e_ctl));
            if (vecs[k].e_ctl[4]) begin
                chk($sformatf("vec%0d_maddr", k), maddr0, vecs[k].e_maddr);
                chk($sformatf("vec%0d_mwdata", k), mwdata0, vecs[k].e_mwdata);
            end
            if (vecs[k].e_ctl[2]) chk($sformatf("vec%0d_idata", k), idata0, vecs[k].mrd);
            if (vecs[k].e_ctl[1]) chk($sformatf("vec%0d_ddata", k), ddata0, vecs[k].mrd);
            tick();
        end

        // Continuous contention with a one-cycle memory: priority vs round-robin.
        apply_reset();
        exp0 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        ival = 1; iaddr = 32'h1000; dval = 1; daddr = 32'h2000; mrdy = 1;
        for (int t = 0; t < 10; t++) begin
            #2;
            e = exp0[t];
            chk($sformatf("prio_grant%0d", t), 32'({irdy0, drdy0}), 32'({~e, e}));
            chk($sformatf("prio_addr%0d", t), maddr0, e ? 32'h2000 : 32'h1000);
            e = (t % 2 == 0);
            chk($sformatf("rr_grant%0d", t), 32'({irdy1, drdy1}), 32'({~e, e}));
            tick();
            mrv = 1; mrd = 32'hA000 + 32'(t);
            #2;
            e = exp0[t];
            chk($sformatf("prio_resp%0d", t), 32'({iresp0, dresp0}), 32'({~e, e}));
            e = (t % 2 == 0);
            chk($sformatf("rr_resp%0d", t), 32'({iresp1, dresp1}), 32'({~e, e}));
            chk($sformatf("rr_rdata%0d", t), e ? ddata1 : idata1, 32'hA000 + 32'(t));
            tick();
            mrv = 0;
        end

        // Reset while a transaction is outstanding; the late response is spurious.
        apply_reset();
        ival = 1; iaddr = 32'h500; mrdy = 1;
        #2;
        chk("busyrst_accept", 32'(irdy0), 32'h1);
        tick();
        ival = 0;
        #2;
        chk("busyrst_busy_mval", 32'(mval0), 32'h0);
        ival = 1;
        rst = 0;
        #1;
        chk("busyrst_in_reset", 32'(ctl0), 32'h0);
        tick();
        rst = 1; ival = 0;
        tick();
        mrv = 1; mrd = 32'h77;
        #2;
        chk("busyrst_late_resp", 32'({iresp0, dresp0}), 32'h0);
        tick();
        mrv = 0;
        #2;
        chk("busyrst_err", 32'(err0), 32'h1);
        ival = 1; iaddr = 32'h600;
        #2;
        chk("busyrst_idle_accept", 32'(irdy0), 32'h1);
        chk("busyrst_idle_addr", maddr0, 32'h600);
        tick();
        ival = 0;
        tick();
        mrv = 1; mrd = 32'hA5A5A5A5;
        #2;
        chk("busyrst_resp", 32'({iresp0, dresp0}), 32'b10);
        chk("busyrst_rdata", idata0, 32'hA5A5A5A5);
        tick();
        mrv = 0;

        // Spurious response in IDLE: err stays set across later traffic.
        apply_reset();
        mrv = 1; mrd = 32'h99;
        #2;
        chk("spur_no_resp", 32'({iresp0, dresp0}), 32'h0);
        tick();
        mrv = 0;
        #2;
        chk("spur_err", 32'(err0), 32'h1);
        for (int t = 0; t < 10; t++) begin
            e = (t % 2 == 1);
            ival = ~e; dval = e; mrdy = 1; iaddr = 32'h40; daddr = 32'h80;
            tick();
            ival = 0; dval = 0;
            mrv = 1; mrd = 32'(t);
            #2;
            chk($sformatf("spur_resp%0d", t), 32'({iresp0, dresp0}), 32'({~e, e}));
            chk($sformatf("spur_sticky%0d", t), 32'(err0), 32'h1);
            tick();
            mrv = 0;
        end
        apply_reset();
        #2;
        chk("spur_cleared", 32'(err0), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
